divider: RTL and testbench



---
 rtl/divider_pkg.sv | 19 +
 rtl/divider_if.sv | 26 ++
 rtl/add_huit.sv | 24 ++
 rtl/divider_step.sv | 30 +++
 rtl/divider.sv | 103 ++++++++++
 tb/tb_divider.sv | 202 ++++++++++++++++++++
 6 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  // FSM state encodings
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Dividend/quotient width, divisor/remainder width, steps per division
  localparam int DW    = 16;
  localparam int VW    = 8;
  localparam int NSTEP = 16;

  // Width of the step counter (counts 0..NSTEP-1)
  localparam int CW = $clog2(NSTEP);

endpackage

// File: rtl/divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface divider_if;
  import divider_pkg::*;

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  // Caller side: issues requests, observes status and results
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );

endinterface

// File: rtl/add_huit.sv
// 8-bit ripple-carry adder: s = a + b + rin, carry-out on rout.
module add_huit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       rin,
  output logic [7:0] s,
  output logic       rout
);

  // Carry chain kept as separate bits so each stage is its own net
  logic c [0:8];

  assign c[0] = rin;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fa
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign rout = c[8];

endmodule

// File: rtl/divider_step.sv
// One restoring-division step: trial-subtract D from T and keep the
// difference when it does not underflow.
module divider_step
  import divider_pkg::*;
(
  input  logic [VW:0]   t,
  input  logic [VW-1:0] d,
  output logic [VW-1:0] p_next,
  output logic          ge
);

  logic [VW-1:0] s;
  logic          c;

  // T - D computed as T[7:0] + ~D + 1
  add_huit u_sub (
    .a    (t[VW-1:0]),
    .b    (~d),
    .rin  (1'b1),
    .s    (s),
    .rout (c)
  );

  // T >= D when T overflows 8 bits or the 8-bit subtraction has no borrow.
  // The partial remainder is always below D afterwards, so it fits 8 bits:
  // on ge it is s, otherwise T itself, whose top bit is then zero.
  assign ge     = t[VW] | c;
  assign p_next = ge ? s : t[VW-1:0];

endmodule

// File: rtl/divider.sv
// 16-by-8 unsigned sequential restoring divider, one quotient bit per clock,
// with a start/busy/done handshake and registered results.
module divider
  import divider_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  divider_if.slave bus
);

  state_t        state_reg;
  logic [VW-1:0] p_reg;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] d_reg;
  logic [CW-1:0] count_reg;

  logic          busy_reg;
  logic          done_reg;
  logic          dbz_reg;
  logic [DW-1:0] quotient_reg;
  logic [VW-1:0] remainder_reg;

  logic [VW:0]   t;
  logic [VW-1:0] p_next;
  logic          ge;
  logic [DW-1:0] q_next;

  // Shift the next dividend bit into the partial remainder
  assign t      = {p_reg, q_reg[DW-1]};
  assign q_next = {q_reg[DW-2:0], ge};

  divider_step u_step (
    .t      (t),
    .d      (d_reg),
    .p_next (p_next),
    .ge     (ge)
  );

  // FSM, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      p_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      count_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              // Divide by zero resolves immediately without iterating
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend[VW-1:0];
              dbz_reg       <= 1'b1;
              done_reg      <= 1'b1;
              state_reg     <= ST_DONE;
            end else begin
              p_reg     <= '0;
              q_reg     <= bus.dividend;
              d_reg     <= bus.divisor;
              count_reg <= '0;
              busy_reg  <= 1'b1;
              state_reg <= ST_RUN;
            end
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_RUN: begin
          p_reg     <= p_next;
          q_reg     <= q_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(NSTEP - 1)) begin
            quotient_reg  <= q_next;
            remainder_reg <= p_next;
            dbz_reg       <= 1'b0;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= ST_DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.dbz       = dbz_reg;

endmodule

// File: tb/tb_divider.sv
// Directed and random-operand bench for the divider, scoreboard-checked.
module tb_divider;

  logic clk;
  logic rst_n;

  divider_if bus ();

  divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int tests;
  int fails;

  logic [15:0] last_q;
  logic [7:0]  last_r;
  logic        last_dbz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge; the expectation goes to the scoreboard
  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv,
                          input logic [15:0] eq, input logic [7:0] er,
                          input logic edbz, input bit hold);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.dbz = edbz;
    e.lat = edbz ? 1 : 17;
    sb.push_back(e);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    $display("[TB] start %0d / %0d", dd, dv);
  endtask

  // Wait for done (bounded), checking busy and held results meanwhile.
  // poke_cycle: raise start for one cycle mid-run; abort_cycle: stop waiting.
  task automatic wait_result(input int poke_cycle, input int abort_cycle);
    exp_t e;
    int   cyc;
    bit   got;
    bit   seen_busy;
    e = sb.pop_front();
    cyc = 0;
    got = 0;
    seen_busy = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == abort_cycle) return;
      if (bus.done === 1'b1) begin
        got = 1;
      end else begin
        if (bus.busy === 1'b1) seen_busy = 1;
        check("busy_run", {31'd0, bus.busy}, 32'd1);
        check("hold_quot", {16'd0, bus.quotient}, {16'd0, last_q});
        check("hold_rem", {24'd0, bus.remainder}, {24'd0, last_r});
        if (cyc == poke_cycle) begin
          bus.dividend = 16'hBEEF;
          bus.divisor  = 8'h11;
          bus.start    = 1'b1;
        end else if (cyc == poke_cycle + 1) begin
          bus.start = 1'b0;
        end
      end
    end
    check("latency", cyc, e.lat);
    check("busy_seen", {31'd0, seen_busy}, (e.lat > 1) ? 32'd1 : 32'd0);
    if (got) begin
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      check("quotient", {16'd0, bus.quotient}, {16'd0, e.q});
      check("remainder", {24'd0, bus.remainder}, {24'd0, e.r});
      check("dbz", {31'd0, bus.dbz}, {31'd0, e.dbz});
      last_q   = e.q;
      last_r   = e.r;
      last_dbz = e.dbz;
    end
    $display("[TB] result q=%0d r=%0d dbz=%0d after %0d cycles",
             bus.quotient, bus.remainder, bus.dbz, cyc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_quot"}, {16'd0, bus.quotient}, 32'd0);
    check({tag, "_rem"}, {24'd0, bus.remainder}, 32'd0);
    check({tag, "_dbz"}, {31'd0, bus.dbz}, 32'd0);
  endtask

  initial begin
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  r;
    logic [15:0] m;

    tests    = 0;
    fails    = 0;
    last_q   = '0;
    last_r   = '0;
    last_dbz = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic, full-scale and small-dividend cases
    start_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b0);
    wait_result(0, 0);
    start_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 1'b0);
    wait_result(0, 0);
    start_op(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 1'b0);
    wait_result(0, 0);
    start_op(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 1'b0);
    wait_result(0, 0);

    // Divide by zero
    start_op(16'h12FF, 8'd0, 16'hFFFF, 8'hFF, 1'b1, 1'b0);
    wait_result(0, 0);
    @(negedge clk);
    check("dbz_done_pulse", {31'd0, bus.done}, 32'd0);

    // Round trip with a product: 200*123
    m = 16'd200 * 16'd123;
    start_op(m, 8'd123, 16'd200, 8'd0, 1'b0, 1'b0);
    wait_result(0, 0);

    // Random pairs built as a*b + r with r < b
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      r = 8'($urandom_range(0, int'(b) - 1));
      m = 16'(a) * 16'(b) + 16'(r);
      start_op(m, b, {8'd0, a}, r, 1'b0, 1'b0);
      wait_result(0, 0);
    end

    // Start held high through a run, then back-to-back request from DONE
    start_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b1);
    wait_result(0, 0);
    start_op(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 1'b0);
    wait_result(0, 0);

    // Start pulse during RUN is ignored
    start_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b0);
    wait_result(5, 0);

    // Reset mid-run discards the computation
    start_op(16'd40000, 8'd13, 16'd3076, 8'd12, 1'b0, 1'b0);
    wait_result(0, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    $display("[TB] reset asserted during run");
    @(negedge clk);
    rst_n = 1'b1;
    last_q   = '0;
    last_r   = '0;
    last_dbz = 1'b0;
    @(negedge clk);
    check_zero("after_reset");

    start_op(16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 1'b0);
    wait_result(0, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
